// File: rtl/vm_change_sequencer_pkg.sv
// Shared constants and state encoding for the vending-machine change sequencer.
package vm_change_sequencer_pkg;

    localparam int unsigned K_NUM_ITEMS  = 4;
    localparam int unsigned K_NUM_COINS  = 3;
    localparam int unsigned K_TOTAL_BITS = 31;
    localparam int unsigned K_VAL_BITS   = 16;
    localparam int unsigned K_STOCK_BITS = 8;
    localparam int unsigned K_INIT_STOCK = 4;

    // Slice k holds the value of coin k; index 0 is the smallest denomination.
    localparam logic [K_NUM_COINS*K_VAL_BITS-1:0] K_COIN_VALUES = {16'd1000, 16'd500, 16'd100};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/vm_coin_selector.sv
// Combinational picker: highest-value coin that fits the remaining amount and is in stock.
module vm_coin_selector
    import vm_change_sequencer_pkg::*;
#(
    parameter int unsigned NUM_COINS  = K_NUM_COINS,
    parameter int unsigned TOTAL_BITS = K_TOTAL_BITS,
    parameter int unsigned VAL_BITS   = K_VAL_BITS,
    parameter int unsigned STOCK_BITS = K_STOCK_BITS,
    parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = K_COIN_VALUES
) (
    input  logic [TOTAL_BITS-1:0]           remaining_i,
    input  logic [NUM_COINS*STOCK_BITS-1:0] stock_i,
    output logic                            found_c,
    output logic [NUM_COINS-1:0]            onehot_c
);

    // Ascending scan so the last (largest) eligible coin wins.
    always_comb begin
        found_c  = 1'b0;
        onehot_c = '0;
        for (int unsigned k = 0; k < NUM_COINS; k++) begin
            if ((TOTAL_BITS'(COIN_VALUES[k*VAL_BITS +: VAL_BITS]) <= remaining_i) &&
                (stock_i[k*STOCK_BITS +: STOCK_BITS] != '0)) begin
                found_c     = 1'b1;
                onehot_c    = '0;
                onehot_c[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_change_sequencer.sv
// Vending-machine output stage: registers item/total outputs and pays out change
// one coin per hopper handshake, largest denomination first, from stock counters.
module vm_change_sequencer
    import vm_change_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = K_NUM_ITEMS,
    parameter int unsigned NUM_COINS  = K_NUM_COINS,
    parameter int unsigned TOTAL_BITS = K_TOTAL_BITS,
    parameter int unsigned VAL_BITS   = K_VAL_BITS,
    parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = K_COIN_VALUES,
    parameter int unsigned STOCK_BITS = K_STOCK_BITS,
    parameter int unsigned INIT_STOCK = K_INIT_STOCK
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_ITEMS-1:0]  available_item_i,
    input  logic [NUM_ITEMS-1:0]  output_item_nxt_i,
    input  logic [TOTAL_BITS-1:0] current_total_nxt_i,
    input  logic                  return_req_i,
    input  logic [NUM_COINS-1:0]  coin_in_i,
    input  logic                  coin_ready_i,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [TOTAL_BITS-1:0] o_current_total,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_shortfall
);

    localparam logic [STOCK_BITS-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);

    state_e                  state_q, state_d;
    logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;
    logic [TOTAL_BITS-1:0]   current_total_q, current_total_d;
    logic [TOTAL_BITS-1:0]   shortfall_q, shortfall_d;
    logic [NUM_ITEMS-1:0]    output_item_q, output_item_d;
    logic [NUM_COINS-1:0]    return_coin_q, return_coin_d;
    logic [STOCK_BITS-1:0]   stock_q [NUM_COINS];
    logic [STOCK_BITS-1:0]   stock_d [NUM_COINS];

    logic [NUM_COINS*STOCK_BITS-1:0] stock_flat_c;
    logic [TOTAL_BITS-1:0]           coin_value_c;
    logic                            handshake_c;
    logic                            found_c;
    logic [NUM_COINS-1:0]            onehot_c;

    vm_coin_selector #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS),
        .VAL_BITS   (VAL_BITS),
        .STOCK_BITS (STOCK_BITS),
        .COIN_VALUES(COIN_VALUES)
    ) u_selector (
        .remaining_i(remaining_q),
        .stock_i    (stock_flat_c),
        .found_c    (found_c),
        .onehot_c   (onehot_c)
    );

    // Flattened stock view and value of the coin currently being presented.
    always_comb begin
        stock_flat_c = '0;
        coin_value_c = '0;
        for (int unsigned k = 0; k < NUM_COINS; k++) begin
            stock_flat_c[k*STOCK_BITS +: STOCK_BITS] = stock_q[k];
            if (return_coin_q[k]) begin
                coin_value_c = TOTAL_BITS'(COIN_VALUES[k*VAL_BITS +: VAL_BITS]);
            end
        end
    end

    assign handshake_c = (state_q == ST_DISPENSE) && coin_ready_i;

    // Refill and payout on the same coin cancel; refills saturate.
    always_comb begin
        for (int unsigned k = 0; k < NUM_COINS; k++) begin
            stock_d[k] = stock_q[k];
            if (handshake_c && return_coin_q[k]) begin
                if (!coin_in_i[k]) begin
                    stock_d[k] = stock_q[k] - STOCK_BITS'(1);
                end
            end else if (coin_in_i[k] && (stock_q[k] != STOCK_MAX)) begin
                stock_d[k] = stock_q[k] + STOCK_BITS'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        current_total_d = current_total_q;
        shortfall_d     = shortfall_q;
        output_item_d   = '0;
        return_coin_d   = return_coin_q;
        case (state_q)
            ST_IDLE: begin
                current_total_d = current_total_nxt_i;
                output_item_d   = output_item_nxt_i;
                if (return_req_i) begin
                    remaining_d   = current_total_q;
                    output_item_d = '0;
                    state_d       = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (found_c) begin
                    return_coin_d = onehot_c;
                    state_d       = ST_DISPENSE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                if (coin_ready_i) begin
                    remaining_d   = remaining_q - coin_value_c;
                    return_coin_d = '0;
                    state_d       = ST_SELECT;
                end
            end
            ST_DONE: begin
                shortfall_d     = remaining_q;
                current_total_d = '0;
                remaining_d     = '0;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            remaining_q     <= '0;
            current_total_q <= '0;
            shortfall_q     <= '0;
            output_item_q   <= '0;
            return_coin_q   <= '0;
            for (int unsigned k = 0; k < NUM_COINS; k++) begin
                stock_q[k] <= STOCK_INIT;
            end
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            current_total_q <= current_total_d;
            shortfall_q     <= shortfall_d;
            output_item_q   <= output_item_d;
            return_coin_q   <= return_coin_d;
            stock_q         <= stock_d;
        end
    end

    assign o_available_item = (state_q == ST_IDLE) ? available_item_i : '0;
    assign o_output_item    = output_item_q;
    assign o_return_coin    = return_coin_q;
    assign o_current_total  = current_total_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_done           = (state_q == ST_DONE);
    assign o_shortfall      = shortfall_q;

endmodule

// File: tb/tb_vm_change_sequencer.sv
// Bench for vm_change_sequencer: directed and randomized returns against a greedy change model.
module tb_vm_change_sequencer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  available_item_i;
    logic [3:0]  output_item_nxt_i;
    logic [30:0] current_total_nxt_i;
    logic        return_req_i;
    logic [2:0]  coin_in_i;
    logic        coin_ready_i;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic [30:0] o_current_total;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_shortfall;

    int pass_cnt;
    int total_cnt;
    int coin_val [3];
    int m_stock  [3];

    vm_change_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .available_item_i   (available_item_i),
        .output_item_nxt_i  (output_item_nxt_i),
        .current_total_nxt_i(current_total_nxt_i),
        .return_req_i       (return_req_i),
        .coin_in_i          (coin_in_i),
        .coin_ready_i       (coin_ready_i),
        .o_available_item   (o_available_item),
        .o_output_item      (o_output_item),
        .o_return_coin      (o_return_coin),
        .o_current_total    (o_current_total),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_shortfall        (o_shortfall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Largest denomination that fits rem and is still in the model's stock, or -1.
    function automatic int pick(input int rem);
        int k;
        k = -1;
        for (int j = 2; j >= 0; j--) begin
            if (k < 0 && coin_val[j] <= rem && m_stock[j] > 0) k = j;
        end
        return k;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_item"},     32'(o_output_item),   0);
        check({tag, "_coin"},     32'(o_return_coin),   0);
        check({tag, "_total"},    32'(o_current_total), 0);
        check({tag, "_busy"},     32'(o_busy),          0);
        check({tag, "_done"},     32'(o_done),          0);
        check({tag, "_shortfall"},32'(o_shortfall),     0);
    endtask

    // Load a total, request a return, hand-shake every coin, and check the outcome.
    task automatic do_return(input int total, input int stall_lo, input int stall_hi, input bit inject);
        int rem;
        int k;
        int stall;
        logic [3:0] itm;
        rem = total;
        itm = 4'($urandom_range(1, 15));
        current_total_nxt_i = 31'(total);
        output_item_nxt_i   = itm;
        available_item_i    = 4'hA;
        tick();
        check("load_total",  32'(o_current_total),  32'(total));
        check("item_strobe", 32'(o_output_item),    32'(itm));
        check("avail_idle",  32'(o_available_item), 32'h0000000A);
        return_req_i = 1'b1;
        tick();
        return_req_i        = 1'b0;
        current_total_nxt_i = 31'($urandom_range(1, 99999));
        output_item_nxt_i   = 4'hF;
        check("busy_select",  32'(o_busy),           1);
        check("item_masked",  32'(o_output_item),    0);
        check("avail_masked", 32'(o_available_item), 0);
        check("select_nocoin",32'(o_return_coin),    0);
        for (int n = 0; n < 64; n++) begin
            k = pick(rem);
            if (k < 0) break;
            tick();
            check("coin_present", 32'(o_return_coin), 32'(1 << k));
            stall = int'($urandom_range(stall_hi, stall_lo));
            repeat (stall) begin
                tick();
                check("coin_hold", 32'(o_return_coin), 32'(1 << k));
            end
            coin_ready_i = 1'b1;
            if (inject) coin_in_i = 3'(1 << k);
            tick();
            coin_ready_i = 1'b0;
            coin_in_i    = 3'b000;
            check("coin_drop", 32'(o_return_coin), 0);
            if (!inject) m_stock[k] = m_stock[k] - 1;
            rem = rem - coin_val[k];
        end
        tick();
        check("done_pulse",  32'(o_done),          1);
        check("done_nocoin", 32'(o_return_coin),   0);
        check("total_held",  32'(o_current_total), 32'(total));
        tick();
        check("done_clear",  32'(o_done),          0);
        check("shortfall",   32'(o_shortfall),     32'(rem));
        check("total_zero",  32'(o_current_total), 0);
        check("back_idle",   32'(o_busy),          0);
    endtask

    task automatic idle_coin_in(input int k);
        coin_in_i = 3'(1 << k);
        tick();
        coin_in_i = 3'b000;
        if (m_stock[k] < 255) m_stock[k] = m_stock[k] + 1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        coin_val  = '{100, 500, 1000};
        m_stock   = '{4, 4, 4};
        reset_n             = 1'b0;
        available_item_i    = 4'h5;
        output_item_nxt_i   = 4'h3;
        current_total_nxt_i = 31'd777;
        return_req_i        = 1'b0;
        coin_in_i           = 3'b000;
        coin_ready_i        = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_avail", 32'(o_available_item), 32'h5);
        reset_n = 1'b1;

        // Abort a return mid-dispense with reset.
        current_total_nxt_i = 31'd1000;
        tick();
        return_req_i = 1'b1;
        tick();
        return_req_i = 1'b0;
        tick();
        check("abort_coin", 32'(o_return_coin), 32'b100);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("abort");
        tick();
        check("abort_nodone", 32'(o_done), 0);
        check("abort_idle",   32'(o_busy), 0);

        do_return(1600, 0, 2, 1'b0);
        do_return(500, 5, 5, 1'b0);
        do_return(3000, 0, 1, 1'b0);
        do_return(100, 0, 1, 1'b1);
        do_return(300, 0, 1, 1'b0);
        do_return(300, 0, 1, 1'b0);
        do_return(0, 0, 0, 1'b0);
        idle_coin_in(0);
        do_return(100, 1, 2, 1'b0);

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) idle_coin_in(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0)
                do_return(int'($urandom_range(0, 30)) * 100, 0, 3, $urandom_range(0, 3) == 0);
            else
                do_return(int'($urandom_range(0, 3000)), 0, 3, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
